// File: rtl/matmul_stream_engine.sv
// rtl/matmul_stream_engine.sv - register-file matrix multiplier streaming C = A*B with raw/ReLU/saturate modes
// Optional build macro: MATMUL_ABORT_EN adds an abort input that cancels a run and returns to IDLE.
module matmul_stream_engine #(
  parameter int M          = 3,
  parameter int N          = 3,
  parameter int P          = 3,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+$clog2(N)
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef MATMUL_ABORT_EN
  input  logic                          abort,
`endif
  input  logic [1:0]                    mode,
  input  logic signed [DATA_WIDTH-1:0]  a_data_in,
  input  logic [$clog2(M*N)-1:0]        a_addr,
  input  logic                          a_wen,
  input  logic signed [DATA_WIDTH-1:0]  b_data_in,
  input  logic [$clog2(N*P)-1:0]        b_addr,
  input  logic                          b_wen,
  input  logic                          start_computation,
  output logic                          busy,
  output logic signed [ACC_WIDTH-1:0]   result_out,
  output logic [$clog2(M*P)-1:0]        result_idx,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic                          computation_done
);

  localparam int AW = $clog2(M*N);
  localparam int BW = $clog2(N*P);
  localparam int RW = $clog2(M*P);
  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int JW = (P > 1) ? $clog2(P) : 1;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  // Depths carry one extra bit so a power-of-two depth is still representable.
  localparam logic [AW:0] A_DEPTH = (AW+1)'(M*N);
  localparam logic [BW:0] B_DEPTH = (BW+1)'(N*P);

  // Saturation window for mode 10, expressed at accumulator width.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2**(DATA_WIDTH-1))-1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_OUTPUT  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                        state_q, state_d;
  logic [IW-1:0]                 i_q, i_d;
  logic [JW-1:0]                 j_q, j_d;
  logic [KW-1:0]                 k_q, k_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [1:0]                    mode_q, mode_d;

  logic signed [DATA_WIDTH-1:0]  a_mem_q [M*N];
  logic signed [DATA_WIDTH-1:0]  b_mem_q [N*P];

  logic [AW-1:0]                 a_rd_idx;
  logic [BW-1:0]                 b_rd_idx;
  logic signed [DATA_WIDTH-1:0]  a_rd, b_rd;
  logic signed [ACC_WIDTH-1:0]   a_ext, b_ext, prod;
  logic signed [ACC_WIDTH-1:0]   result_val;
  logic                          last_k, last_j, last_i;
  logic                          abort_req;

`ifdef MATMUL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Operand fetch and one signed product per cycle: A[i][k] * B[k][j].
  always_comb begin
    a_rd_idx = AW'(int'(i_q) * N + int'(k_q));
    b_rd_idx = BW'(int'(k_q) * P + int'(j_q));
    a_rd     = a_mem_q[a_rd_idx];
    b_rd     = b_mem_q[b_rd_idx];
    a_ext    = {{(ACC_WIDTH-DATA_WIDTH){a_rd[DATA_WIDTH-1]}}, a_rd};
    b_ext    = {{(ACC_WIDTH-DATA_WIDTH){b_rd[DATA_WIDTH-1]}}, b_rd};
    prod     = a_ext * b_ext;
  end

  assign last_k = (k_q == KW'(N-1));
  assign last_j = (j_q == JW'(P-1));
  assign last_i = (i_q == IW'(M-1));

  // Host writes land only while idle and only for in-range addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < M*N; e++) a_mem_q[e] <= '0;
      for (int e = 0; e < N*P; e++) b_mem_q[e] <= '0;
    end else if (state_q == S_IDLE) begin
      if (a_wen && ({1'b0, a_addr} < A_DEPTH)) a_mem_q[a_addr] <= a_data_in;
      if (b_wen && ({1'b0, b_addr} < B_DEPTH)) b_mem_q[b_addr] <= b_data_in;
    end
  end

  // State, loop counters, accumulator and latched mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state: accumulate N products, present the element, then step j/i.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_computation) begin
          state_d = S_COMPUTE;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          mode_d  = mode;
        end
      end
      S_COMPUTE: begin
        acc_d = acc_q + prod;
        if (last_k) begin
          k_d     = '0;
          state_d = S_OUTPUT;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_OUTPUT: begin
        if (result_ready) begin
          if (last_i && last_j) begin
            state_d = S_DONE;
          end else begin
            acc_d   = '0;
            k_d     = '0;
            state_d = S_COMPUTE;
            if (last_j) begin
              j_d = '0;
              i_d = i_q + IW'(1);
            end else begin
              j_d = j_q + JW'(1);
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Cancelling a run wins over any handshake in the same cycle.
    if (abort_req && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // Result shaping: 01 clips negatives, 10 clamps to the operand range, 00/11 pass through.
  always_comb begin
    result_val = acc_q;
    unique case (mode_q)
      2'b01: begin
        if (acc_q[ACC_WIDTH-1]) result_val = '0;
      end
      2'b10: begin
        if (acc_q > SAT_MAX)      result_val = SAT_MAX;
        else if (acc_q < SAT_MIN) result_val = SAT_MIN;
      end
      default: result_val = acc_q;
    endcase
  end

  // Outputs decode from the state; data and index are zero outside OUTPUT.
  always_comb begin
    busy             = (state_q != S_IDLE);
    result_valid     = (state_q == S_OUTPUT);
    computation_done = (state_q == S_DONE);
    result_out       = '0;
    result_idx       = '0;
    if (state_q == S_OUTPUT) begin
      result_out = result_val;
      result_idx = RW'(int'(i_q) * P + int'(j_q));
    end
  end

endmodule

// File: tb/tb_matmul_stream_engine.sv
// tb/tb_matmul_stream_engine.sv - randomized and directed bench for matmul_stream_engine against a loop-level model
module tb_matmul_stream_engine;

  localparam int M  = 3;
  localparam int N  = 3;
  localparam int P  = 3;
  localparam int DW = 8;
  localparam int AW = 2*DW+$clog2(N);
  localparam int NE = M*P;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [1:0]           mode = 2'b00;
  logic signed [DW-1:0] a_data_in = '0;
  logic [3:0]           a_addr = '0;
  logic                 a_wen = 1'b0;
  logic signed [DW-1:0] b_data_in = '0;
  logic [3:0]           b_addr = '0;
  logic                 b_wen = 1'b0;
  logic                 start_computation = 1'b0;
  logic                 busy;
  logic signed [AW-1:0] result_out;
  logic [3:0]           result_idx;
  logic                 result_valid;
  logic                 result_ready = 1'b1;
  logic                 computation_done;
`ifdef MATMUL_ABORT_EN
  logic                 abort = 1'b0;
`endif

  always #5 clk = ~clk;

  matmul_stream_engine #(.M(M), .N(N), .P(P), .DATA_WIDTH(DW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
`ifdef MATMUL_ABORT_EN
    .abort             (abort),
`endif
    .mode              (mode),
    .a_data_in         (a_data_in),
    .a_addr            (a_addr),
    .a_wen             (a_wen),
    .b_data_in         (b_data_in),
    .b_addr            (b_addr),
    .b_wen             (b_wen),
    .start_computation (start_computation),
    .busy              (busy),
    .result_out        (result_out),
    .result_idx        (result_idx),
    .result_valid      (result_valid),
    .result_ready      (result_ready),
    .computation_done  (computation_done)
  );

  int checks = 0;
  int errors = 0;
  int ma [M*N];
  int mb [N*P];
  logic signed [AW-1:0] exp_c [NE];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain triple loop over integer matrices, then the mode rule.
  function automatic void model(input logic [1:0] md);
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < P; c++) begin
        int s;
        s = 0;
        for (int k = 0; k < N; k++) s += ma[r*N+k] * mb[k*P+c];
        if (md == 2'b01 && s < 0) s = 0;
        if (md == 2'b10) begin
          if (s > 127) s = 127;
          if (s < -128) s = -128;
        end
        exp_c[r*P+c] = AW'(s);
      end
    end
  endfunction

  task automatic load_mats();
    for (int e = 0; e < 9; e++) begin
      @(posedge clk); #1;
      a_wen = 1'b1; a_addr = 4'(e); a_data_in = 8'(ma[e]);
      b_wen = 1'b1; b_addr = 4'(e); b_data_in = 8'(mb[e]);
    end
    @(posedge clk); #1;
    a_wen = 1'b0; b_wen = 1'b0;
  endtask

  task automatic set_identity();
    for (int e = 0; e < 9; e++) begin
      ma[e] = (e / 3 == e % 3) ? 1 : 0;
      mb[e] = ma[e];
    end
  endtask

  task automatic set_const(input int av, input int bv);
    for (int e = 0; e < 9; e++) begin
      ma[e] = av;
      mb[e] = bv;
    end
  endtask

  task automatic run_check(input logic [1:0] md, input int stall_idx, input int stall_len,
                           input bit inject, input string tag);
    int cyc, nres, first, done_at, done_cnt, stall_left;
    model(md);
    @(posedge clk); #1;
    mode = md; start_computation = 1'b1; result_ready = 1'b1;
    cyc = 0; nres = 0; first = -1; done_at = -1; done_cnt = 0; stall_left = stall_len;
    while (cyc < 2000 && !(done_at >= 0 && cyc >= done_at + 3)) begin
      @(posedge clk); #1;
      cyc++;
      start_computation = 1'b0;
      a_wen = 1'b0;
      mode = 2'($urandom);
      if (inject && cyc == 5) begin
        start_computation = 1'b1;
        a_wen = 1'b1; a_addr = 4'd0; a_data_in = 8'sd9;
      end
      if (computation_done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (result_valid) begin
        if (first < 0) begin
          first = cyc;
          check($sformatf("%s busy_at_first_valid", tag), 64'(busy), 64'd1);
        end
        if (nres < NE) begin
          check($sformatf("%s idx_%0d", tag, nres), 64'(result_idx), 64'(nres));
          check($sformatf("%s val_%0d", tag, nres), 64'(result_out), 64'(exp_c[nres]));
        end
        if (int'(result_idx) == stall_idx && stall_left > 0) begin
          result_ready = 1'b0;
          stall_left--;
        end else begin
          result_ready = 1'b1;
          nres++;
        end
      end
    end
    result_ready = 1'b1;
    check($sformatf("%s element_count", tag), 64'(nres), 64'(NE));
    check($sformatf("%s first_valid_cycle", tag), 64'(first), 64'(N+1));
    check($sformatf("%s done_cycle", tag), 64'(done_at), 64'(NE*(N+1)+1+stall_len));
    check($sformatf("%s done_pulses", tag), 64'(done_cnt), 64'd1);
    check($sformatf("%s busy_after", tag), 64'(busy), 64'd0);
  endtask

  // Starts an identity-mode run and stops in COMPUTE of element 2.
  task automatic go_to_idx2(input string tag);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    mode = 2'b00; start_computation = 1'b1; result_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      start_computation = 1'b0;
      if (result_valid && result_idx == 4'd1) begin
        ok = 1'b1;
        break;
      end
    end
    check($sformatf("%s reach_idx1", tag), 64'(ok), 64'd1);
    @(posedge clk); #1;
    check($sformatf("%s in_compute_valid", tag), 64'(result_valid), 64'd0);
    check($sformatf("%s in_compute_busy", tag), 64'(busy), 64'd1);
  endtask

  initial begin
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset valid", 64'(result_valid), 64'd0);
    check("reset done", 64'(computation_done), 64'd0);
    check("reset out", 64'(result_out), 64'd0);
    check("reset idx", 64'(result_idx), 64'd0);
    rst_n = 1'b1;

    set_identity();
    load_mats();
    run_check(2'b00, -1, 0, 1'b0, "ident");

    set_const(-1, 2);
    load_mats();
    run_check(2'b00, -1, 0, 1'b0, "neg_raw");
    run_check(2'b01, -1, 0, 1'b0, "neg_relu");
    run_check(2'b11, -1, 0, 1'b0, "neg_mode3");

    set_const(127, 127);
    load_mats();
    run_check(2'b10, -1, 0, 1'b0, "sat_pos");
    run_check(2'b00, -1, 0, 1'b0, "raw_pos");
    set_const(-128, 127);
    load_mats();
    run_check(2'b10, -1, 0, 1'b0, "sat_neg");

    set_identity();
    load_mats();
    run_check(2'b00, 4, 5, 1'b0, "stall");
    run_check(2'b00, -1, 0, 1'b1, "inject");
    run_check(2'b00, -1, 0, 1'b0, "after_inject");

    for (int t = 0; t < 4; t++) begin
      for (int e = 0; e < 9; e++) begin
        ma[e] = int'($urandom_range(0, 255)) - 128;
        mb[e] = int'($urandom_range(0, 255)) - 128;
      end
      load_mats();
      run_check(2'($urandom_range(0, 3)), int'($urandom_range(0, 8)), int'($urandom_range(0, 4)),
                1'b0, $sformatf("rand%0d", t));
    end

    set_identity();
    load_mats();
    go_to_idx2("rst");
    #2;
    rst_n = 1'b0;
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst valid", 64'(result_valid), 64'd0);
    check("rst done", 64'(computation_done), 64'd0);
    check("rst out", 64'(result_out), 64'd0);
    check("rst idx", 64'(result_idx), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst no_done", 64'(computation_done), 64'd0);
    end
    set_const(0, 0);
    run_check(2'b00, -1, 0, 1'b0, "cleared_mem");
    set_identity();
    load_mats();
    run_check(2'b00, -1, 0, 1'b0, "reload");

`ifdef MATMUL_ABORT_EN
    go_to_idx2("abort");
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort valid", 64'(result_valid), 64'd0);
    check("abort done", 64'(computation_done), 64'd0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("abort no_done", 64'(computation_done), 64'd0);
    end
    run_check(2'b00, -1, 0, 1'b0, "after_abort");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_stream_engine.md
Name: matmul_stream_engine

Overview:
Parametrised successor to the matrix accelerator top. Holds operand matrices A (MxN) and B (NxP) in internal register files and computes C = A·B with one signed MAC unit. C is streamed out row-major over a valid/ready handshake, with a 2-bit mode selecting raw, ReLU or saturated results. Sits between the host load interface and downstream result consumers.

Parameters:
M, 3, rows of A / rows of C
N, 3, cols of A = rows of B (inner dimension)
P, 3, cols of B / cols of C
DATA_WIDTH, 8, signed operand width
ACC_WIDTH, 2*DATA_WIDTH+$clog2(N), signed accumulator/result width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mode  in  2  00 A·B, 01 ReLU(A·B), 10 saturate A·B to DATA_WIDTH, 11 treated as 00
a_data_in  in  DATA_WIDTH  A write data, signed
a_addr  in  $clog2(M*N)  A address, row-major
a_wen  in  1  A write enable
b_data_in  in  DATA_WIDTH  B write data, signed
b_addr  in  $clog2(N*P)  B address, row-major
b_wen  in  1  B write enable
start_computation  in  1  start pulse
busy  out  1  high from accepted start until done pulse
result_out  out  ACC_WIDTH  current C element, signed
result_idx  out  $clog2(M*P)  row-major index of result_out
result_valid  out  1  result_out/result_idx valid
result_ready  in  1  consumer accepts the element when valid&&ready
computation_done  out  1  one-cycle pulse after the last element is accepted

Behaviour:
- Reset (async): state IDLE; A and B memories cleared to 0; all outputs 0; i, j, k, acc cleared.
- Writes: only in IDLE. Addresses >= M*N (A) or >= N*P (B) are ignored. Writes while busy are ignored. Memory updates on the clock edge.
- mode is sampled on the accepted start edge and held for the whole run.
- FSM IDLE -> COMPUTE -> OUTPUT -> (COMPUTE | DONE) -> IDLE.
- IDLE: start_computation=1 -> COMPUTE. On the same edge: i=j=k=0, acc=0, busy=1. Start while busy is ignored.
- COMPUTE: each cycle acc += sext(A[i][k])*sext(B[k][j]) and k increments. After N cycles (k=N-1 consumed) -> OUTPUT.
- OUTPUT: result_valid=1, result_idx=i*P+j, result_out=f(acc). Value and index hold stable until valid&&ready.
  - On handshake, if not the last element: advance j (wrap to 0 and i++), clear acc and k, go to COMPUTE. result_valid drops.
  - On handshake of the last element (i=M-1, j=P-1): go to DONE.
- DONE: computation_done=1 for one cycle, busy=0 on the next edge, -> IDLE.
- f(acc):
  - 00: acc unchanged.
  - 01: acc<0 ? 0 : acc.
  - 10: clamp acc to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], then sign-extend to ACC_WIDTH.
- Latency: first result_valid N+1 cycles after the start edge. With ready held high, each element costs N+1 cycles. computation_done rises M*P*(N+1)+1 cycles after start.
- No overflow is possible: ACC_WIDTH covers N products.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No done pulse.

Optional Feature:
MATMUL_ABORT_EN: adds input port abort (1 bit).
- With the macro: abort=1 in COMPUTE/OUTPUT/DONE returns the FSM to IDLE on the next edge. result_valid, busy and computation_done go to 0, and no done pulse is produced. Memories are preserved. abort in IDLE has no effect. abort takes priority over a simultaneous handshake.
- Without the macro: no abort port, and behaviour is exactly as above.

Test Plan:
- A=B=I3, mode 00, ready=1 -> result_idx 0..8, values 1,0,0,0,1,0,0,0,1. First valid 4 cycles after start. Done pulse 37 cycles after start.
- A all 0xFF (-1), B all 0x02, mode 00 -> all nine results = -6 (18-bit 0x3FFFA). Rerun with mode 01 -> all 0.
- A all 127, B all 127, mode 10 -> all results 127 (raw 48387 clamped). A all -128, B all 127 -> all -128.
- Identity run with result_ready low for 5 cycles while idx 4 is valid -> valid stays high, result_out=1 and idx=4 stable throughout. Total done time increases by 5 cycles.
- Pulse start and a_wen (addr 0, data 9) mid-run -> both ignored. Results unchanged, one done pulse only.
- Assert rst_n=0 during COMPUTE of idx 2 -> all outputs 0 immediately, no done pulse. After release, a fresh load and run passes. With MATMUL_ABORT_EN, abort at idx 2 -> IDLE next cycle, memories kept, rerun gives the identity result.
